clk_div_cfg_seq: RTL and testbench
==================================

# clk_div_cfg_seq

Run-time reconfiguration sequencer for an integer clock divider. It accepts a new divide value from the register side and, before loading it, gates the divided clock off. It then hands the value to the divider over a valid/ready handshake, waits for the divider output to settle, and re-enables the gate. The block sits between the clock/reset control registers and one integer divider instance plus its output clock gate, all in the source clock domain.

## Interface
Parameters:
- DIV_WIDTH, 8: width of divide values.
- DEFAULT_DIV, 2: divide value held after reset; must be non-zero and less than 2^DIV_WIDTH.
- GATE_LAT, 2: cycles waited after gate_en_o falls before the load, covering the clock-gate latch.
- TIMEOUT_CYCLES, 64: maximum wait for div_ready_i (used only under the macro below).

Ports:
- clk_i, in, 1: source clock.
- rst_n_i, in, 1: reset, asynchronous, active-low.
- en_i, in, 1: divided-clock enable requested by software.
- cfg_div_i, in, DIV_WIDTH: requested divide value.
- cfg_valid_i, in, 1: request valid.
- cfg_ready_o, out, 1: request accepted when high together with cfg_valid_i.
- div_o, out, DIV_WIDTH: value presented to the divider.
- div_valid_o, out, 1: div_o valid.
- div_ready_i, in, 1: divider accepts div_o.
- gate_en_o, out, 1: enable for the clock gate on the divider output.
- cur_div_o, out, DIV_WIDTH: divide value currently active.
- busy_o, out, 1: high whenever the state is not IDLE.
- err_o, out, 1: one-cycle pulse on a rejected request or a timeout.

## Operation
- State machine: IDLE -> GATE_OFF -> LOAD -> SETTLE -> IDLE.
- IDLE:
  - cfg_ready_o = 1.
  - On a handshake with cfg_div_i == 0: err_o pulses; no other change.
  - On a handshake with cfg_div_i == cur_div_o: accepted as a no-op; state stays IDLE.
  - Otherwise: the value is latched into a pending register and the FSM moves to GATE_OFF.
- GATE_OFF: gate_en_o = 0; wait GATE_LAT cycles, then go to LOAD.
- LOAD:
  - div_valid_o = 1, div_o = pending value; both stay stable until div_ready_i.
  - On the handshake: cur_div_o takes the pending value; go to SETTLE.
- SETTLE: wait 2*cur_div_o cycles, then go to IDLE. The counter is DIV_WIDTH+1 bits, so no overflow is possible.
- gate_en_o is registered: its next value is en_i in IDLE and 0 in every other state. en_i never aborts a running sequence.
- div_o equals cur_div_o outside LOAD.
- cfg_ready_o = 0 outside IDLE. A held cfg_valid_i simply waits.

## Timing
- Reset values:
  - Outputs: cfg_ready_o = 0, div_valid_o = 0, gate_en_o = 0, busy_o = 0, err_o = 0, div_o = cur_div_o = DEFAULT_DIV.
  - First cycle after reset release: state IDLE, cfg_ready_o = 1.
  - gate_en_o follows en_i with one cycle of latency.
- Accepted change at cycle T:
  - busy_o = 1 and gate_en_o = 0 from T+1.
  - LOAD begins at T+1+GATE_LAT.
- Handshake at cycle L: cur_div_o updates at L+1, and SETTLE spans L+1 .. L+2*new_div.
- After SETTLE:
  - IDLE, with cfg_ready_o = 1, at L+2*new_div+1.
  - gate_en_o = en_i one cycle later.
- A rejected request pulses err_o exactly at T+1.
- Reset asserted mid-sequence returns the block immediately to the reset values. The pending value is discarded.

## Configuration
- CLK_DIV_SEQ_TIMEOUT_EN defined:
  - LOAD lasts at most TIMEOUT_CYCLES cycles.
  - On expiry: div_valid_o drops, err_o pulses, cur_div_o stays unchanged, and the FSM enters SETTLE using the old value before re-enabling the gate.
- CLK_DIV_SEQ_TIMEOUT_EN undefined: LOAD waits indefinitely for div_ready_i, and err_o fires only for zero requests.

## Structure
- Package clk_div_seq_pkg:
  - State enum (IDLE, GATE_OFF, LOAD, SETTLE).
  - Localparam for the counter width, DIV_WIDTH+1.
- Sub-module clk_div_seq_cnt: a loadable down-counter with a zero flag. One instance is shared by GATE_OFF, SETTLE and the timeout.
- Registers use the codebase's dffr-style flops.

## Test plan
- Reset with en_i = 1 -> cur_div_o = 2, gate_en_o = 0 during reset and 1 from the second cycle after release; busy_o = 0.
- Request 6 with GATE_LAT = 2 and div_ready_i = 1 -> gate_en_o low from T+1, div_valid_o high for 1 cycle at T+3, cur_div_o = 6 at T+4, cfg_ready_o back at T+16.
- Request 0, then request equal to cur_div_o -> err_o pulse at T+1 for the first; no busy_o for either; cur_div_o unchanged.
- div_ready_i held low for 10 cycles during LOAD -> div_valid_o and div_o = 6 stable throughout; en_i toggling during that time leaves gate_en_o = 0.
- rst_n_i asserted during SETTLE -> outputs return to reset values asynchronously, cur_div_o = DEFAULT_DIV.
- With CLK_DIV_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES = 64, div_ready_i never high -> err_o pulse after 64 LOAD cycles, cur_div_o unchanged, gate re-enabled after 2*old_div cycles.

Source files
------------

// File: rtl/clk_div_seq_pkg.sv
// Shared types for the clock-divider reconfiguration sequencer.
package clk_div_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_GATE_OFF = 2'd1,
        ST_LOAD     = 2'd2,
        ST_SETTLE   = 2'd3
    } state_t;

    // One extra bit so the counter can hold 2*max_div without overflow
    localparam int unsigned CNT_EXTRA_BITS = 1;

    function automatic int unsigned cnt_width(input int unsigned div_width);
        return div_width + CNT_EXTRA_BITS;
    endfunction

endpackage

// File: rtl/clk_div_seq_cnt.sv
// Loadable down-counter with zero flag; saturates at zero.
module clk_div_seq_cnt
    import clk_div_seq_pkg::*;
#(
    parameter int unsigned WIDTH = cnt_width(8)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/clk_div_cfg_seq.sv
// Run-time divide-value sequencer: gate off, load over valid/ready, settle, re-gate.
// Optional LOAD timeout enabled by defining CLK_DIV_SEQ_TIMEOUT_EN.
module clk_div_cfg_seq
    import clk_div_seq_pkg::*;
#(
    parameter int unsigned DIV_WIDTH      = 8,
    parameter int unsigned DEFAULT_DIV    = 2,
    parameter int unsigned GATE_LAT       = 2,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 en_i,
    input  logic [DIV_WIDTH-1:0] cfg_div_i,
    input  logic                 cfg_valid_i,
    output logic                 cfg_ready_o,
    output logic [DIV_WIDTH-1:0] div_o,
    output logic                 div_valid_o,
    input  logic                 div_ready_i,
    output logic                 gate_en_o,
    output logic [DIV_WIDTH-1:0] cur_div_o,
    output logic                 busy_o,
    output logic                 err_o
);

    localparam int unsigned CNT_W = cnt_width(DIV_WIDTH);

    state_t               r_state, w_next;
    logic [DIV_WIDTH-1:0] r_pend, r_cur;
    logic                 r_err, r_gate, r_cfg_ready;

    logic                 w_hs_cfg, w_zero_req, w_accept, w_load_hs, w_timeout;
    logic                 w_cnt_load, w_cnt_dec, w_cnt_zero;
    logic [CNT_W-1:0]     w_cnt_val;

    // r_cfg_ready is only high while IDLE, so it doubles as the request handshake qualifier
    assign w_hs_cfg   = cfg_valid_i && r_cfg_ready;
    assign w_zero_req = w_hs_cfg && (cfg_div_i == '0);
    assign w_accept   = w_hs_cfg && (cfg_div_i != '0) && (cfg_div_i != r_cur);
    assign w_load_hs  = (r_state == ST_LOAD) && div_ready_i;

`ifdef CLK_DIV_SEQ_TIMEOUT_EN
    assign w_timeout  = (r_state == ST_LOAD) && !div_ready_i && w_cnt_zero;
`else
    assign w_timeout  = 1'b0;
`endif

    always_comb begin
        w_next     = r_state;
        w_cnt_load = 1'b0;
        w_cnt_dec  = 1'b0;
        w_cnt_val  = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next     = ST_GATE_OFF;
                    w_cnt_load = 1'b1;
                    w_cnt_val  = CNT_W'(GATE_LAT - 1);
                end
            end
            ST_GATE_OFF: begin
                if (w_cnt_zero) begin
                    w_next     = ST_LOAD;
                    w_cnt_load = 1'b1;
                    w_cnt_val  = CNT_W'(TIMEOUT_CYCLES - 1);
                end else begin
                    w_cnt_dec  = 1'b1;
                end
            end
            ST_LOAD: begin
                if (w_load_hs) begin
                    w_next     = ST_SETTLE;
                    w_cnt_load = 1'b1;
                    w_cnt_val  = {r_pend, 1'b0} - CNT_W'(1);
                end else if (w_timeout) begin
                    w_next     = ST_SETTLE;
                    w_cnt_load = 1'b1;
                    w_cnt_val  = {r_cur, 1'b0} - CNT_W'(1);
                end else begin
                    w_cnt_dec  = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (w_cnt_zero) begin
                    w_next    = ST_IDLE;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= ST_IDLE;
            r_pend      <= DIV_WIDTH'(DEFAULT_DIV);
            r_cur       <= DIV_WIDTH'(DEFAULT_DIV);
            r_err       <= 1'b0;
            r_gate      <= 1'b0;
            r_cfg_ready <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_err       <= w_zero_req || w_timeout;
            r_gate      <= en_i && r_cfg_ready && (r_state == ST_IDLE) && !w_accept;
            r_cfg_ready <= (w_next == ST_IDLE);
            if (w_accept) begin
                r_pend <= cfg_div_i;
            end
            if (w_load_hs) begin
                r_cur <= r_pend;
            end
        end
    end

    clk_div_seq_cnt #(
        .WIDTH (CNT_W)
    ) u_cnt (
        .i_clk      (clk_i),
        .i_rst_n    (rst_n_i),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_val),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_cnt_zero)
    );

    assign cfg_ready_o = r_cfg_ready;
    assign div_valid_o = (r_state == ST_LOAD);
    assign div_o       = (r_state == ST_LOAD) ? r_pend : r_cur;
    assign gate_en_o   = r_gate;
    assign cur_div_o   = r_cur;
    assign busy_o      = (r_state != ST_IDLE);
    assign err_o       = r_err;

endmodule

// File: tb/tb_clk_div_cfg_seq.sv
// Bench for clk_div_cfg_seq: timestamp-based reference model plus directed literal checks.
module tb_clk_div_cfg_seq;

    localparam int DW  = 8;
    localparam int DEF = 2;
    localparam int GL  = 2;
    localparam int TO  = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [DW-1:0] cdiv;
    logic          cvalid;
    logic          cready;
    logic [DW-1:0] div_o;
    logic          dvalid;
    logic          dready;
    logic          gate;
    logic [DW-1:0] cur;
    logic          busy;
    logic          err;

    int total = 0;
    int pass  = 0;
    int cyc   = 0;

    clk_div_cfg_seq #(
        .DIV_WIDTH      (DW),
        .DEFAULT_DIV    (DEF),
        .GATE_LAT       (GL),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .en_i        (en),
        .cfg_div_i   (cdiv),
        .cfg_valid_i (cvalid),
        .cfg_ready_o (cready),
        .div_o       (div_o),
        .div_valid_o (dvalid),
        .div_ready_i (dready),
        .gate_en_o   (gate),
        .cur_div_o   (cur),
        .busy_o      (busy),
        .err_o       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) $display("FAIL %s @cyc %0d: got %0d expected %0d", nm, cyc, act, exp);
        else            pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_until(input int n);
        for (int i = 0; i < 2000 && cyc < n; i++) tick();
        chk("wait_until", cyc, n);
    endtask

    // Reference model: a sequence is described by its accept time and derived timestamps
    bit m_seq    = 0;
    int m_cur    = DEF;
    int m_n      = 0;
    int m_load   = 0;
    int m_L      = -1;
    int m_idle   = 1 << 30;
    bit m_err    = 0;
    bit m_gate   = 0;

    always @(negedge clk) begin
        int  c;
        bit  e_ready, e_valid, acc;
        int  e_div;
        c = cyc;
        if (!rst_n) begin
            chk("rst_ready", int'(cready), 0);
            chk("rst_busy",  int'(busy),   0);
            chk("rst_dvalid",int'(dvalid), 0);
            chk("rst_gate",  int'(gate),   0);
            chk("rst_err",   int'(err),    0);
            chk("rst_cur",   int'(cur),    DEF);
            chk("rst_div",   int'(div_o),  DEF);
            m_seq = 0; m_cur = DEF; m_L = -1; m_idle = 1 << 30; m_err = 0; m_gate = 0;
        end else begin
            e_ready = (c >= 1) && !m_seq;
            e_valid = m_seq && (c >= m_load) && (m_L < 0 || c <= m_L);
            e_div   = e_valid ? m_n : m_cur;
            chk("m_ready",  int'(cready), int'(e_ready));
            chk("m_busy",   int'(busy),   int'(m_seq));
            chk("m_dvalid", int'(dvalid), int'(e_valid));
            chk("m_div",    int'(div_o),  e_div);
            chk("m_cur",    int'(cur),    m_cur);
            chk("m_gate",   int'(gate),   int'(m_gate));
            chk("m_err",    int'(err),    int'(m_err));

            acc    = e_ready && cvalid && (int'(cdiv) != 0) && (int'(cdiv) != m_cur);
            m_err  = e_ready && cvalid && (int'(cdiv) == 0);
            m_gate = e_ready && en && !acc;
            if (acc) begin
                m_seq  = 1;
                m_n    = int'(cdiv);
                m_load = c + 1 + GL;
                m_L    = -1;
                m_idle = 1 << 30;
            end else if (m_seq && m_L < 0 && c >= m_load) begin
                if (dready) begin
                    m_L    = c;
                    m_idle = c + 2 * m_n + 1;
                    m_cur  = m_n;
                end
`ifdef CLK_DIV_SEQ_TIMEOUT_EN
                else if (c == m_load + TO - 1) begin
                    m_L    = c;
                    m_idle = c + 2 * m_cur + 1;
                    m_err  = 1;
                end
`endif
            end else if (m_seq && c + 1 == m_idle) begin
                m_seq = 0;
            end
        end
    end

    initial begin
        int t0;
        rst_n = 1'b0; en = 1'b1; cvalid = 1'b0; cdiv = '0; dready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("lit_reset_gate", int'(gate), 0);
        chk("lit_reset_cur",  int'(cur),  2);
        rst_n = 1'b1;
        tick();
        chk("lit_first_ready", int'(cready), 1);
        chk("lit_first_gate",  int'(gate),   0);
        chk("lit_first_busy",  int'(busy),   0);
        tick();
        chk("lit_second_gate", int'(gate),   1);

        // Request 6 at T=4
        wait_until(4);
        cvalid = 1'b1; cdiv = 8'd6;
        tick(); cvalid = 1'b0;
        chk("lit_A_gate_off", int'(gate), 0);
        chk("lit_A_busy",     int'(busy), 1);
        wait_until(7);
        chk("lit_A_dvalid",   int'(dvalid), 1);
        chk("lit_A_div",      int'(div_o),  6);
        tick();
        chk("lit_A_dvalid_drop", int'(dvalid), 0);
        chk("lit_A_cur",         int'(cur),    6);
        wait_until(19);
        chk("lit_A_ready_T15", int'(cready), 0);
        tick();
        chk("lit_A_ready_T16", int'(cready), 1);
        tick();
        chk("lit_A_regate",    int'(gate),   1);

        // Zero request then same-value request
        wait_until(24);
        cvalid = 1'b1; cdiv = 8'd0;
        tick(); cvalid = 1'b0;
        chk("lit_B_err",  int'(err),  1);
        chk("lit_B_busy", int'(busy), 0);
        tick();
        chk("lit_B_err_clear", int'(err), 0);
        wait_until(27);
        cvalid = 1'b1; cdiv = 8'd6;
        tick(); cvalid = 1'b0;
        chk("lit_B_noop_busy", int'(busy), 0);
        chk("lit_B_noop_err",  int'(err),  0);
        chk("lit_B_noop_cur",  int'(cur),  6);

        // Stalled LOAD for 10 cycles with en toggling
        wait_until(30);
        dready = 1'b0; cvalid = 1'b1; cdiv = 8'd5;
        tick(); cvalid = 1'b0;
        wait_until(33);
        for (int i = 0; i < 10; i++) begin
            chk("lit_C_dvalid", int'(dvalid), 1);
            chk("lit_C_div",    int'(div_o),  5);
            chk("lit_C_gate",   int'(gate),   0);
            en = ~en;
            tick();
        end
        en = 1'b1; dready = 1'b1;
        chk("lit_C_still_valid", int'(dvalid), 1);
        tick();
        chk("lit_C_cur", int'(cur), 5);
        wait_until(53);
        chk("lit_C_ready_before", int'(cready), 0);
        tick();
        chk("lit_C_ready_back",   int'(cready), 1);

`ifdef CLK_DIV_SEQ_TIMEOUT_EN
        // Divider never ready: LOAD cycles 61..124, err at 125, idle at 135
        wait_until(58);
        dready = 1'b0; cvalid = 1'b1; cdiv = 8'd9;
        tick(); cvalid = 1'b0;
        wait_until(124);
        chk("lit_T_last_load", int'(dvalid), 1);
        tick();
        chk("lit_T_err",    int'(err),    1);
        chk("lit_T_dvalid", int'(dvalid), 0);
        chk("lit_T_cur",    int'(cur),    5);
        wait_until(136);
        chk("lit_T_regate", int'(gate),   1);
        dready = 1'b1;
`endif

        // Asynchronous reset in SETTLE
        t0 = cyc + 2;
        wait_until(t0);
        cvalid = 1'b1; cdiv = 8'd3;
        tick(); cvalid = 1'b0;
        wait_until(t0 + 6);
        chk("lit_D_busy", int'(busy), 1);
        chk("lit_D_cur",  int'(cur),  3);
        rst_n = 1'b0;
        #1;
        chk("lit_D_async_busy",  int'(busy),   0);
        chk("lit_D_async_cur",   int'(cur),    DEF);
        chk("lit_D_async_div",   int'(div_o),  DEF);
        chk("lit_D_async_gate",  int'(gate),   0);
        chk("lit_D_async_ready", int'(cready), 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("lit_D_after_cur", int'(cur), DEF);

        // Held request waits through its own sequence, then becomes a no-op
        cvalid = 1'b1; cdiv = 8'd7;
        repeat (30) tick();
        cvalid = 1'b0;
        chk("lit_E_cur", int'(cur), 7);
        repeat (5) tick();

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule
